// File: rtl/pc_link_ctrl.sv
// Program-counter and call/return controller feeding link_reg.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_link_ctrl #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic [1:0]      op,
    input  logic            br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] LR,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] lr_in,
    output logic            lr_en,
    output logic            ras_err
);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    typedef enum logic [1:0] {OP_SEQ = 2'b00, OP_BR = 2'b01, OP_BL = 2'b10, OP_RET = 2'b11} op_t;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_check
        $error("RAS_DEPTH must be a power of 2 and at least 2");
    end

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    op_t             op_e;

    assign op_e   = op_t'(op);
    assign pc_inc = pc + PC_W'(1);
    assign lr_in  = pc_inc;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W:0]   count;
    logic             ras_empty;
    logic             ras_full;
    logic             push;
    logic             pop;

    assign top_inc   = top + PTR_W'(1);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == (PTR_W+1)'(RAS_DEPTH));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RESET_VEC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a value unassigned (no latches).
    always_comb begin
        state_next = state;
        pc_next    = pc;
        lr_en      = 1'b0;
`ifdef PC_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (state)
            BOOT: state_next = halt ? HALTED : RUN;
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (!stall) begin
                    case (op_e)
                        OP_SEQ: pc_next = pc_inc;
                        OP_BR:  pc_next = br_cond ? br_target : pc_inc;
                        OP_BL: begin
                            if (br_cond) begin
                                pc_next = br_target;
                                lr_en   = 1'b1;
`ifdef PC_RAS_EN
                                push    = 1'b1;
`endif
                            end else begin
                                pc_next = pc_inc;
                            end
                        end
                        OP_RET: begin
`ifdef PC_RAS_EN
                            pop     = 1'b1;
                            pc_next = ras_empty ? LR : ras_mem[top];
`else
                            pc_next = LR;
`endif
                        end
                    endcase
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = BOOT;
        endcase
    end

`ifdef PC_RAS_EN
    // Circular stack: a push when full advances over the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top     <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else begin
            ras_err <= 1'b0;
            if (push) begin
                top <= top_inc;
                if (ras_full) ras_err <= 1'b1;
                else          count   <= count + 1'b1;
            end else if (pop) begin
                if (ras_empty) begin
                    ras_err <= 1'b1;
                end else begin
                    top   <= top - PTR_W'(1);
                    count <= count - 1'b1;
                end
            end
        end
    end

    // NOTE: the stack storage has no reset; count/top define which entries
    // are valid, so the contents never need clearing.
    always_ff @(posedge clk) begin
        if (push) ras_mem[top_inc] <= pc_inc;
    end
`else
    assign ras_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_link_ctrl.sv
// Directed self-checking bench for pc_link_ctrl, with a behavioural link_reg.
// Stack checks are compiled in when PC_RAS_EN is defined.
module tb_pc_link_ctrl;

    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, BL = 2'b10, RET = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, halt, br_cond;
    logic [1:0] op;
    logic [7:0] br_target;
    logic [7:0] lr_q;
    logic [7:0] pc, lr_in;
    logic       lr_en, ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_link_ctrl #(.PC_W(8), .RESET_VEC(8'h00), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .op(op),
        .br_cond(br_cond), .br_target(br_target), .LR(lr_q),
        .pc(pc), .lr_in(lr_in), .lr_en(lr_en), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // Downstream link register.
    always @(posedge clk or negedge rst) begin
        if (!rst)       lr_q <= 8'h00;
        else if (lr_en) lr_q <= lr_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic c, input logic [7:0] t);
        op = o; br_cond = c; br_target = t;
        #1;
    endtask

    task automatic jump_to(input logic [7:0] t);
        drive(BR, 1'b1, t);
        tick();
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; halt = 1'b0;
        drive(BL, 1'b1, 8'h77);
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 8'h00);
        check("reset_lr_en", lr_en, 1'b0);
        check("reset_ras_err", ras_err, 1'b0);

        // BOOT cycle ignores a taken BL.
        rst = 1'b1;
        #1;
        check("boot_pc", pc, 8'h00);
        check("boot_lr_en", lr_en, 1'b0);
        tick();
        check("boot_exit_pc", pc, 8'h00);
        drive(SEQ, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("seq_pc_%0d", i), pc, i);
        end

        // Taken BL from 05 to 40.
        jump_to(8'h05);
        check("br_pc", pc, 8'h05);
        drive(BL, 1'b1, 8'h40);
        check("bl_lr_en", lr_en, 1'b1);
        check("bl_lr_in", lr_in, 8'h06);
        tick();
        check("bl_pc", pc, 8'h40);
        check("bl_link", lr_q, 8'h06);

        drive(RET, 1'b0, 8'h00);
        check("ret_lr_en", lr_en, 1'b0);
        tick();
        check("ret_pc", pc, 8'h06);

        // Stall holds pc and blocks the link write even for a taken BL.
        stall = 1'b1;
        drive(BL, 1'b1, 8'h55);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_lr_en_%0d", i), lr_en, 1'b0);
            tick();
            check($sformatf("stall_pc_%0d", i), pc, 8'h06);
        end
        stall = 1'b0;

        jump_to(8'h10);
        drive(BR, 1'b0, 8'h80);
        tick();
        check("br_not_taken", pc, 8'h11);
        drive(BL, 1'b0, 8'h80);
        check("bl_not_taken_lr_en", lr_en, 1'b0);
        tick();
        check("bl_not_taken_pc", pc, 8'h12);

        // BL to itself, then BL and an immediate RET.
        drive(BL, 1'b1, 8'h12);
        check("bl_self_lr_in", lr_in, 8'h13);
        tick();
        check("bl_self_pc", pc, 8'h12);
        check("bl_self_link", lr_q, 8'h13);
        drive(BL, 1'b1, 8'h30);
        tick();
        drive(RET, 1'b0, 8'h00);
        tick();
        check("ret_after_bl", pc, 8'h13);

        // Wrap-around of pc+1.
        jump_to(8'hFF);
        drive(SEQ, 1'b0, 8'h00);
        tick();
        check("wrap_seq", pc, 8'h00);
        jump_to(8'hFF);
        drive(BL, 1'b1, 8'h20);
        check("wrap_lr_in", lr_in, 8'h00);
        tick();
        check("wrap_bl_pc", pc, 8'h20);
        check("wrap_bl_link", lr_q, 8'h00);
        check("no_ras_err", ras_err, 1'b0);

        // Halt is sticky and outranks a taken branch.
        halt = 1'b1;
        drive(BR, 1'b1, 8'h99);
        tick();
        check("halt_pc", pc, 8'h20);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) ? BL : BR, 1'b1, 8'h99);
            check($sformatf("halted_lr_en_%0d", i), lr_en, 1'b0);
            tick();
            check($sformatf("halted_pc_%0d", i), pc, 8'h20);
        end

        // Asynchronous reset between edges.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 8'h00);
        check("async_rst_lr_en", lr_en, 1'b0);
        tick();
        rst = 1'b1;
        drive(SEQ, 1'b0, 8'h00);
        tick();
        tick();
        check("post_rst_pc", pc, 8'h01);

`ifdef PC_RAS_EN
        // Five nested calls into a four-deep stack.
        jump_to(8'h01);
        for (int i = 0; i < 5; i++) begin
            drive(BL, 1'b1, 8'h11 + 8'(i * 16));
            tick();
            check($sformatf("nest_pc_%0d", i), pc, 8'h11 + 8'(i * 16));
            check($sformatf("nest_err_%0d", i), ras_err, (i == 4) ? 1'b1 : 1'b0);
        end
        drive(RET, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("pop_pc_%0d", i), pc, 8'h42 - 8'(i * 16));
            check($sformatf("pop_err_%0d", i), ras_err, 1'b0);
        end
        tick();
        check("underflow_pc", pc, 8'h42);
        check("underflow_err", ras_err, 1'b1);
        drive(SEQ, 1'b0, 8'h00);
        tick();
        check("err_pulse_clear", ras_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
